ub_arbiter: RTL

Unibus bus arbiter and interrupt acceptor for the CPU side of the fpga11 bus: the other end of the BR/BG/SACK/INTR handshake that peripherals such as the DL11 and KW11-L drive. It resolves NPR and BR7–BR4 requests, issues the daisy-chained grant, accepts the interrupt vector from the winning device, answers with SSYN, and hands the vector to the CPU core. It performs no data transfers itself; it only sequences bus mastership and interrupt vector reception.

---
 rtl/ub_arbiter_pkg.sv | 46 ++++
 rtl/ub_timeout.sv | 33 +++
 rtl/ub_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ub_arbiter_pkg.sv
// Shared types and constants for the Unibus arbiter: FSM states, request
// levels and the highest-request picker.
package ub_arbiter_pkg;

  localparam int GRANT_TIMEOUT_DEF = 500;
  localparam int BR_LEVEL_MIN      = 4;
  localparam int BR_LEVELS         = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_NPG        = 3'd1,
    ST_NPR_MASTER = 3'd2,
    ST_BG         = 3'd3,
    ST_BR_MASTER  = 3'd4,
    ST_ACK        = 3'd5,
    ST_HOLD       = 3'd6
  } arb_state_t;

  // idx is the request level minus BR_LEVEL_MIN (0 = BR4 .. 3 = BR7)
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } br_pick_t;

  function automatic br_pick_t highest_br(input logic [3:0] br);
    br_pick_t pick;
    pick.valid = |br;
    pick.idx   = 2'd0;
    for (int i = 0; i < BR_LEVELS; i++) begin
      if (br[i]) begin
        pick.idx = 2'(i);
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] level_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // True when request level (BR_LEVEL_MIN + idx) outranks the CPU priority.
  function automatic logic level_above(input logic [1:0] idx, input logic [2:0] prio);
    return ({1'b1, idx} > prio);
  endfunction

endpackage

// File: rtl/ub_timeout.sv
// Grant watchdog: cleared by load, counts while enabled, flags when the
// grant has been held for LIMIT clocks (checked on the withdrawing edge).
module ub_timeout
  import ub_arbiter_pkg::*;
#(
  parameter int LIMIT = GRANT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (count_en && (count_reg != W'(LIMIT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg trails the grant age by one, so LIMIT-1 here means the grant
  // drops exactly LIMIT clocks after it rose.
  assign expired = (count_reg >= W'(LIMIT - 1));

endmodule

// File: rtl/ub_arbiter.sv
// Unibus arbiter and interrupt acceptor: resolves NPR/BR requests, issues
// grants, accepts the interrupt vector with SSYN and hands it to the CPU.
module ub_arbiter
  import ub_arbiter_pkg::*;
#(
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  input  logic [7:4]  bus_br,
  input  logic        bus_npr,
  input  logic        bus_sack,
  input  logic        bus_bbsy,
  input  logic        bus_intr,
  input  logic [15:0] bus_d,
  output logic [7:4]  bus_bg_out,
  output logic        bus_npg_out,
  output logic        bus_ssyn_out,
  input  logic [2:0]  cpu_prio,
  input  logic        cpu_inst_end,
  output logic        irq_valid,
  output logic [8:0]  irq_vector,
  input  logic        irq_taken
);

  arb_state_t state_reg, state_next;
  logic [1:0] level_reg, level_next;
  logic [3:0] bg_reg, bg_next;
  logic       npg_reg, npg_next;
  logic       ssyn_reg, ssyn_next;
  logic       irq_valid_reg, irq_valid_next;
  logic [8:0] irq_vector_reg, irq_vector_next;

  logic       timer_load;
  logic       timer_en;
  logic       timer_expired;
  logic       capture;
  br_pick_t   pick;
  logic [3:0] br_vec;

  // Only bus_d[8:2] carry vector bits.
  logic unused_bus_d;
  assign unused_bus_d = ^{bus_d[15:9], bus_d[1:0]};

  assign br_vec   = bus_br;
  assign pick     = highest_br(br_vec);
  assign timer_en = (state_reg == ST_NPG) || (state_reg == ST_BG);

  ub_timeout #(
    .LIMIT (GRANT_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load | bus_init),
    .count_en (timer_en),
    .expired  (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    bg_next    = bg_reg;
    npg_next   = npg_reg;
    ssyn_next  = ssyn_reg;
    timer_load = 1'b0;
    capture    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus_npr) begin
          state_next = ST_NPG;
          npg_next   = 1'b1;
          timer_load = 1'b1;
        end else if (cpu_inst_end && !irq_valid_reg && pick.valid &&
                     level_above(pick.idx, cpu_prio)) begin
          state_next = ST_BG;
          level_next = pick.idx;
          bg_next    = level_onehot(pick.idx);
          timer_load = 1'b1;
        end
      end

      ST_NPG: begin
        if (bus_sack) begin
          state_next = ST_NPR_MASTER;
          npg_next   = 1'b0;
        end else if (timer_expired || !bus_npr) begin
          state_next = ST_IDLE;
          npg_next   = 1'b0;
        end
      end

      ST_NPR_MASTER: begin
        if (!bus_sack && !bus_bbsy) begin
          state_next = ST_IDLE;
        end
      end

      ST_BG: begin
        // level_reg is frozen for the whole grant; later BR changes are ignored
        if (bus_sack) begin
          state_next = ST_BR_MASTER;
          bg_next    = '0;
        end else if (timer_expired || !br_vec[level_reg]) begin
          state_next = ST_IDLE;
          bg_next    = '0;
        end
      end

      ST_BR_MASTER: begin
        if (bus_intr) begin
          state_next = ST_ACK;
          ssyn_next  = 1'b1;
          capture    = 1'b1;
        end else if (!bus_bbsy && !bus_sack) begin
          state_next = ST_IDLE;
        end
      end

      ST_ACK: begin
        if (!bus_intr) begin
          state_next = ST_HOLD;
          ssyn_next  = 1'b0;
        end
      end

      ST_HOLD: begin
        if (!bus_bbsy) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        bg_next    = '0;
        npg_next   = 1'b0;
        ssyn_next  = 1'b0;
      end
    endcase
  end

  // A fresh capture outranks a simultaneous irq_taken.
  always_comb begin
    irq_valid_next  = irq_valid_reg;
    irq_vector_next = irq_vector_reg;
    if (capture) begin
      irq_valid_next  = 1'b1;
      irq_vector_next = {bus_d[8:2], 2'b00};
    end else if (irq_taken) begin
      irq_valid_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      level_reg      <= 2'd0;
      bg_reg         <= '0;
      npg_reg        <= 1'b0;
      ssyn_reg       <= 1'b0;
      irq_valid_reg  <= 1'b0;
      irq_vector_reg <= '0;
    end else if (bus_init) begin
      state_reg      <= ST_IDLE;
      level_reg      <= 2'd0;
      bg_reg         <= '0;
      npg_reg        <= 1'b0;
      ssyn_reg       <= 1'b0;
      irq_valid_reg  <= 1'b0;
      irq_vector_reg <= '0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      bg_reg         <= bg_next;
      npg_reg        <= npg_next;
      ssyn_reg       <= ssyn_next;
      irq_valid_reg  <= irq_valid_next;
      irq_vector_reg <= irq_vector_next;
    end
  end

  assign bus_bg_out   = bg_reg;
  assign bus_npg_out  = npg_reg;
  assign bus_ssyn_out = ssyn_reg;
  assign irq_valid    = irq_valid_reg;
  assign irq_vector   = irq_vector_reg;

endmodule
